// File: rtl/parallax_scroll_sequencer_if.sv
// Control/status bundle for the parallax scroll sequencer.
// The master drives the frame controls, the slave returns offsets and status.
interface parallax_scroll_sequencer_if;
    logic        frame_start;
    logic        pause;
    logic        reverse;
    logic [1:0]  speed;
    logic        home;
    logic [49:0] off_x;
    logic [49:0] off_y;
    logic [9:0]  frame_count;
    logic        busy;
    logic        done;
    logic        overrun;

    modport master (
        output frame_start, pause, reverse, speed, home,
        input  off_x, off_y, frame_count, busy, done, overrun
    );

    modport slave (
        input  frame_start, pause, reverse, speed, home,
        output off_x, off_y, frame_count, busy, done, overrun
    );
endinterface

// File: rtl/parallax_scroll_sequencer.sv
// Per-frame scroll sequencer: sweeps ten layer/axis accumulators through one
// shared adder during vblank, then publishes all integer offsets in a single edge.
module parallax_scroll_sequencer #(
    parameter int FRAC_BITS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    parallax_scroll_sequencer_if.slave  bus
);
    localparam int ACC_W = 10 + FRAC_BITS;

    typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;

    state_t                 state, state_nxt;
    logic [3:0]             idx;
    logic                   rev_q;
    logic [1:0]             spd_q;
    logic [9:0][ACC_W-1:0]  acc;
    logic [49:0]            offx_q, offy_q;
    logic [9:0]             fcnt_q;
    logic                   done_q, ovr_q;
    logic                   start;
    logic [ACC_W-1:0]       addend, sum;

    // Velocity table in 1/16 px, rescaled to the configured fraction width.
    // Even idx is the X axis, odd idx the Y axis, layers a..e in order.
    function automatic logic [ACC_W-1:0] vel(input logic [3:0] i);
        int v;
        case (i)
            4'd0: v = 256;  4'd1: v = 32;
            4'd2: v = 112;  4'd3: v = 24;
            4'd4: v = 64;   4'd5: v = 8;
            4'd6: v = 32;   4'd7: v = 4;
            4'd8: v = 8;    4'd9: v = 3;
            default: v = 0;
        endcase
        return ACC_W'((v << FRAC_BITS) >> 4);
    endfunction

    assign start  = bus.frame_start && !bus.pause && !bus.home;
    assign addend = vel(idx) << spd_q;
    assign sum    = rev_q ? acc[idx] - addend : acc[idx] + addend;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = UPDATE;
            UPDATE:  if (idx == 4'd9) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.home) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            offx_q <= '0;
            offy_q <= '0;
            fcnt_q <= '0;
            done_q <= 1'b0;
            ovr_q  <= 1'b0;
            idx    <= '0;
            rev_q  <= 1'b0;
            spd_q  <= '0;
        end else if (bus.home) begin
            // overrun is deliberately left alone so a home doesn't hide a past overrun
            acc    <= '0;
            offx_q <= '0;
            offy_q <= '0;
            fcnt_q <= '0;
            done_q <= 1'b0;
            idx    <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.frame_start && state != IDLE) ovr_q <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    idx   <= '0;
                    rev_q <= bus.reverse;
                    spd_q <= bus.speed;
                end
                UPDATE: begin
                    acc[idx] <= sum;
                    idx      <= idx + 4'd1;
                end
                COMMIT: begin
                    for (int l = 0; l < 5; l++) begin
                        offx_q[l*10 +: 10] <= acc[2*l][FRAC_BITS +: 10];
                        offy_q[l*10 +: 10] <= acc[2*l+1][FRAC_BITS +: 10];
                    end
                    fcnt_q <= fcnt_q + 10'd1;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.off_x       = offx_q;
    assign bus.off_y       = offy_q;
    assign bus.frame_count = fcnt_q;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.overrun     = ovr_q;
endmodule

// File: tb/tb_parallax_scroll_sequencer.sv
// Directed bench for parallax_scroll_sequencer with hand-computed expectations.
module tb_parallax_scroll_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    logic saw_done;

    parallax_scroll_sequencer_if bus();

    parallax_scroll_sequencer #(.FRAC_BITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Leaves time just after E0.
    task automatic start_frame(input logic rev, input logic [1:0] spd);
        bus.frame_start = 1'b1;
        bus.reverse     = rev;
        bus.speed       = spd;
        tick();
        bus.frame_start = 1'b0;
    endtask

    // Leaves time just after E11, where done is high.
    task automatic run_frame(input logic rev, input logic [1:0] spd);
        start_frame(rev, spd);
        repeat (11) tick();
    endtask

    task automatic watch_done(input int n);
        saw_done = 1'b0;
        repeat (n) begin
            tick();
            if (bus.done) saw_done = 1'b1;
        end
    endtask

    function automatic logic [9:0] lx(input int l);
        return bus.off_x[l*10 +: 10];
    endfunction

    function automatic logic [9:0] ly(input int l);
        return bus.off_y[l*10 +: 10];
    endfunction

    initial begin
        rst_n           = 1'b0;
        bus.frame_start = 1'b0;
        bus.pause       = 1'b0;
        bus.reverse     = 1'b0;
        bus.speed       = 2'd0;
        bus.home        = 1'b0;
        do_reset();

        chk("rst_off_x", bus.off_x, 0);
        chk("rst_off_y", bus.off_y, 0);
        chk("rst_fcnt", bus.frame_count, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ovr", bus.overrun, 0);

        // first frame, cycle-accurate latency
        start_frame(1'b0, 2'd0);
        chk("f1_busy_e0", bus.busy, 1);
        repeat (10) tick();
        chk("f1_busy_e10", bus.busy, 1);
        chk("f1_done_e10", bus.done, 0);
        chk("f1_stable_x", bus.off_x, 0);
        tick();
        chk("f1_done_e11", bus.done, 1);
        chk("f1_busy_e11", bus.busy, 0);
        chk("f1_off_x", bus.off_x, {10'd0, 10'd2, 10'd4, 10'd7, 10'd16});
        chk("f1_off_y", bus.off_y, {10'd0, 10'd0, 10'd0, 10'd1, 10'd2});
        chk("f1_fcnt", bus.frame_count, 1);
        tick();
        chk("f1_done_drop", bus.done, 0);

        // second frame
        run_frame(1'b0, 2'd0);
        chk("f2_off_x", bus.off_x, {10'd1, 10'd4, 10'd8, 10'd14, 10'd32});
        chk("f2_off_y", bus.off_y, {10'd0, 10'd0, 10'd1, 10'd3, 10'd4});
        chk("f2_fcnt", bus.frame_count, 2);

        // reverse wraps below zero
        do_reset();
        run_frame(1'b1, 2'd0);
        chk("rev_ax", lx(0), 1008);
        chk("rev_ay", ly(0), 1022);
        chk("rev_ex", lx(4), 1023);

        // 64 forward frames wrap a.x back to 0
        do_reset();
        repeat (64) run_frame(1'b0, 2'd0);
        chk("wrap_ax", lx(0), 0);
        chk("wrap_bx", lx(1), 448);
        chk("wrap_fcnt", bus.frame_count, 64);

        // speed 3, with speed/reverse changed mid-sweep
        do_reset();
        start_frame(1'b0, 2'd3);
        repeat (3) tick();
        bus.speed   = 2'd0;
        bus.reverse = 1'b1;
        repeat (8) tick();
        chk("spd_ax", lx(0), 128);
        chk("spd_ay", ly(0), 16);
        chk("spd_bx", lx(1), 56);
        chk("spd_cx", lx(2), 32);
        chk("spd_ey", ly(4), 1);
        bus.reverse = 1'b0;

        // overrun: second frame_start during the sweep
        do_reset();
        start_frame(1'b0, 2'd0);
        repeat (5) tick();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        chk("ovr_flag", bus.overrun, 1);
        chk("ovr_busy", bus.busy, 1);
        repeat (5) tick();
        chk("ovr_done", bus.done, 1);
        chk("ovr_fcnt", bus.frame_count, 1);
        chk("ovr_off_x", bus.off_x, {10'd0, 10'd2, 10'd4, 10'd7, 10'd16});
        watch_done(14);
        chk("ovr_no_2nd_done", saw_done, 0);
        chk("ovr_fcnt_hold", bus.frame_count, 1);
        chk("ovr_sticky", bus.overrun, 1);

        // paused frame_start does nothing
        bus.pause       = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        chk("pause_busy", bus.busy, 0);
        watch_done(12);
        bus.pause = 1'b0;
        chk("pause_no_done", saw_done, 0);
        chk("pause_fcnt", bus.frame_count, 1);

        // home during the sweep
        start_frame(1'b0, 2'd0);
        repeat (6) tick();
        bus.home = 1'b1;
        tick();
        bus.home = 1'b0;
        chk("home_busy", bus.busy, 0);
        chk("home_off_x", bus.off_x, 0);
        chk("home_off_y", bus.off_y, 0);
        chk("home_fcnt", bus.frame_count, 0);
        chk("home_done", bus.done, 0);
        chk("home_ovr_kept", bus.overrun, 1);
        watch_done(12);
        chk("home_no_done", saw_done, 0);

        // home together with frame_start acts as home only
        bus.home        = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        bus.home        = 1'b0;
        bus.frame_start = 1'b0;
        chk("home_fs_busy", bus.busy, 0);
        watch_done(12);
        chk("home_fs_no_done", saw_done, 0);

        // reset mid-sweep discards it
        start_frame(1'b0, 2'd0);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_ovr", bus.overrun, 0);
        watch_done(12);
        chk("rst_mid_no_done", saw_done, 0);
        chk("rst_mid_fcnt", bus.frame_count, 0);
        chk("rst_mid_off_x", bus.off_x, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/parallax_scroll_sequencer.md
PARALLAX_SCROLL_SEQUENCER -- requirements
Module: parallax_scroll_sequencer

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 4, meaning fractional bits per accumulator; accumulator width is 10+FRAC_BITS.
REQ-002 SHALL have port clk, input, 1, pixel clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-004 SHALL have port frame_start, input, 1, one-cycle pulse at start of vertical blanking.
REQ-005 SHALL have port pause, input, 1, when high, frame_start is ignored.
REQ-006 SHALL have port reverse, input, 1, when high, velocities are subtracted.
REQ-007 SHALL have port speed, input, 2, velocity left-shift amount (0..3).
REQ-008 SHALL have port home, input, 1, synchronous clear of all scroll positions.
REQ-009 SHALL have port off_x, output, 50, layer X offsets: layer a [9:0], b [19:10], c [29:20], d [39:30], e [49:40].
REQ-010 SHALL have port off_y, output, 50, layer Y offsets, packed as off_x.
REQ-011 SHALL have port frame_count, output, 10, count of committed frames.
REQ-012 SHALL have port busy, output, 1, high in UPDATE and COMMIT.
REQ-013 SHALL have port done, output, 1, one-cycle pulse when new offsets become visible.
REQ-014 SHALL have port overrun, output, 1, sticky flag for frame_start received while busy.

Function
REQ-015 SHALL hold ten accumulators, (layer, axis), each 10+FRAC_BITS wide, with fixed velocities in units of 1/16 px (FRAC_BITS=4).
- a: x 256, y 32
- b: x 112, y 24
- c: x 64, y 8
- d: x 32, y 4
- e: x 8, y 3
REQ-016 SHALL implement FSM states IDLE, UPDATE, COMMIT.
REQ-017 In IDLE, with frame_start=1, pause=0 and home=0 at an edge, SHALL latch reverse and speed, set idx=0, and enter UPDATE.
REQ-018 In UPDATE, SHALL update one accumulator per cycle using a single shared adder/subtractor.
- Order: idx 0..9 = a.x, a.y, b.x, b.y, … e.y.
- Update: acc <= acc ± (vel << speed_latched), modulo 2^(10+FRAC_BITS).
- After idx 9, SHALL enter COMMIT.
REQ-019 In COMMIT, SHALL copy the integer part acc[FRAC_BITS+9:FRAC_BITS] of all ten accumulators to off_x/off_y in one edge, increment frame_count (wrapping 1023→0), pulse done for exactly the following cycle, and return to IDLE.
REQ-020 Timing: frame_start sampled at edge E0; outputs change and done rises at edge E11; busy is high from after E0 to E11.
REQ-021 Outputs SHALL be stable between commits (no partial-sweep values visible).
REQ-022 Pause handling: frame_start with pause=1 in IDLE SHALL cause no state change, no frame_count increment, and no done.
REQ-023 Overrun: frame_start while busy SHALL be ignored, set overrun=1, and not disturb the sweep.
REQ-024 home=1 SHALL take priority over everything at any state.
- Clears accumulators, off_x, off_y, and frame_count to 0.
- Aborts any sweep and goes to IDLE.
- done=0; overrun is unchanged.
REQ-025 home and frame_start in the same cycle SHALL act as home only.

Reset
REQ-026 rst_n=0 at an edge SHALL set the following, with priority over home:
- state IDLE
- all accumulators, off_x, off_y, frame_count = 0
- busy, done, overrun = 0
REQ-027 Reset asserted mid-sweep SHALL discard the sweep with no commit.

Verification
REQ-028 Bench SHALL cover: reset, then 1 frame_start (speed 0, forward) -> at E11 done=1.
- X offsets a=16, b=7, c=4, d=2, e=0; Y offsets a=2, b=1, c=0, d=0, e=0.
- frame_count=1.
REQ-029 Bench SHALL cover: 2 frames -> b.y=3, c.y=1, d.y=0, e.x=1, e.y=0, a.x=32.
REQ-030 Bench SHALL cover: 1 frame, reverse=1 -> a.x=1008, a.y=1022, e.x=1023; then 64 forward frames at speed 0 from reset -> a.x=0 (wrap), frame_count=64.
REQ-031 Bench SHALL cover: speed=3 for 1 frame -> a.x=128, a.y=16, b.x=56; speed changed mid-sweep has no effect on that sweep.
REQ-032 Bench SHALL cover: frame_start at cycle 5 of a sweep -> overrun=1, single commit, frame_count+1 only; pause=1 frame_start -> no done.
REQ-033 Bench SHALL cover: home at cycle 6 of a sweep -> next cycle busy=0, all offsets 0, no done pulse.
